// File: rtl/fu_ctrl_pkg.sv
// fu_ctrl_pkg: shared function-select codes, opcodes, FSM encodings and instruction field positions.
package fu_ctrl_pkg;
  localparam logic [4:0] FS_MOVA = 5'b00000;
  localparam logic [4:0] FS_ADD  = 5'b00010;
  localparam logic [4:0] FS_SUB  = 5'b00101;
  localparam logic [4:0] FS_DEC  = 5'b00111;
  localparam logic [4:0] FS_AND  = 5'b01000;
  localparam logic [4:0] FS_OR   = 5'b01010;
  localparam logic [4:0] FS_XOR  = 5'b01100;
  localparam logic [4:0] FS_NOT  = 5'b01110;
  localparam logic [4:0] FS_LSR  = 5'b10000;
  localparam logic [4:0] FS_LSL  = 5'b10001;
  localparam logic [6:0] OPC_BZ  = 7'b1100000;
  localparam logic [6:0] OPC_BN  = 7'b1100001;
  localparam logic [6:0] OPC_BC  = 7'b1100010;
  localparam logic [6:0] OPC_BV  = 7'b1100011;
  localparam logic [6:0] OPC_NOP = 7'b1111111;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_BRANCH = 2'd2;
  localparam int OPC_LSB = 25;
  localparam int DR_LSB  = 20;
  localparam int SA_LSB  = 15;
  localparam int SB_LSB  = 10;
  localparam int SH_LSB  = 0;
  localparam int IMM_LSB = 0;
  function automatic logic fs_legal(input logic [4:0] fs);
    return fs inside {FS_MOVA, FS_ADD, FS_SUB, FS_DEC, FS_AND, FS_OR, FS_XOR, FS_NOT, FS_LSR, FS_LSL};
  endfunction
endpackage

// File: rtl/fu_opcode_decode.sv
// fu_opcode_decode: combinational opcode classifier; BC/BV are legal only when FU_FLAG_REG_EN is defined.
module fu_opcode_decode
  import fu_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic [4:0] o_fs,
  output logic       o_mb,
  output logic       o_is_alu,
  output logic       o_is_branch,
  output logic [1:0] o_br_sel,
  output logic       o_legal
);
  logic w_alu, w_br, w_nop;
  assign w_alu = !i_opcode[6];
`ifdef FU_FLAG_REG_EN
  assign w_br = i_opcode[6:2] == OPC_BZ[6:2];
`else
  assign w_br = i_opcode[6:1] == OPC_BZ[6:1];
`endif
  assign w_nop       = i_opcode == OPC_NOP;
  assign o_is_alu    = w_alu;
  assign o_is_branch = w_br;
  assign o_fs        = w_alu ? i_opcode[4:0] : FS_MOVA;
  assign o_mb        = w_alu & i_opcode[5];
  assign o_br_sel    = i_opcode[1:0];
  assign o_legal     = w_alu ? fs_legal(i_opcode[4:0]) : (w_br | w_nop);
endmodule

// File: rtl/fu_issue_ctrl.sv
// fu_issue_ctrl: decode/issue FSM (IDLE/ISSUE/BRANCH) driving the function unit and register file.
// FU_FLAG_REG_EN adds the STATUS flag register and the BC/BV branches.
module fu_issue_ctrl
  import fu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 15,
  parameter int REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [31:0]       i_instr,
  input  logic              i_hold,
  input  logic              i_z,
  input  logic              i_c,
  input  logic              i_n,
  input  logic              i_v,
  output logic              o_issue_valid,
  output logic [4:0]        o_fs,
  output logic [4:0]        o_sh,
  output logic [REG_AW-1:0] o_aa,
  output logic [REG_AW-1:0] o_ba,
  output logic [REG_AW-1:0] o_da,
  output logic              o_mb,
  output logic [DATA_W-1:0] o_imm,
  output logic              o_rw,
  output logic              o_br_taken,
  output logic [IMM_W-1:0]  o_br_offset,
  output logic              o_illegal,
  output logic [3:0]        o_status
);
  logic [1:0]  r_state;
  logic [31:0] r_instr;
  logic        r_cond;
  logic [1:0]  w_next;
  logic [1:0]  w_br_sel;
  logic [3:0]  w_status;
  logic        w_issue, w_commit, w_accept, w_to_branch, w_cond;
  logic        w_is_alu, w_is_branch, w_legal;
  fu_opcode_decode u_dec (
    .i_opcode    (r_instr[OPC_LSB +: 7]),
    .o_fs        (o_fs),
    .o_mb        (o_mb),
    .o_is_alu    (w_is_alu),
    .o_is_branch (w_is_branch),
    .o_br_sel    (w_br_sel),
    .o_legal     (w_legal)
  );
  assign w_issue     = r_state == ST_ISSUE;
  assign w_commit    = w_issue & !i_hold;
  assign w_to_branch = w_commit & w_is_branch & w_legal;
  assign o_in_ready  = (r_state == ST_IDLE) | (w_commit & !(w_is_branch & w_legal));
  assign w_accept    = i_in_valid & o_in_ready;
  // BC/BV read the stored flags, so a branch never sees the flags of a later op
  assign w_cond = w_br_sel == 2'd0 ? i_z :
                  w_br_sel == 2'd1 ? i_n :
                  w_br_sel == 2'd2 ? w_status[2] : w_status[0];
  assign w_next = r_state == ST_BRANCH ? ST_IDLE :
                  w_accept             ? ST_ISSUE :
                  w_issue & i_hold     ? ST_ISSUE :
                  w_to_branch          ? ST_BRANCH : ST_IDLE;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_instr <= '0;
      r_cond  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_instr <= i_instr;
      if (w_to_branch) r_cond <= w_cond;
    end
  end
`ifdef FU_FLAG_REG_EN
  logic [3:0] r_status;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_status <= '0;
    else if (w_commit & w_is_alu & w_legal) r_status <= {i_z, i_c, i_n, i_v};
  end
  assign w_status = r_status;
`else
  assign w_status = '0;
`endif
  assign o_status      = w_status;
  assign o_issue_valid = w_issue;
  assign o_sh          = r_instr[SH_LSB +: 5];
  assign o_aa          = r_instr[SA_LSB +: REG_AW];
  assign o_ba          = r_instr[SB_LSB +: REG_AW];
  assign o_da          = r_instr[DR_LSB +: REG_AW];
  assign o_imm         = {{(DATA_W-IMM_W){1'b0}}, r_instr[IMM_LSB +: IMM_W]};
  assign o_rw          = w_commit & w_is_alu & w_legal;
  assign o_illegal     = w_commit & !w_legal;
  assign o_br_taken    = (r_state == ST_BRANCH) & r_cond;
  assign o_br_offset   = r_state == ST_BRANCH ? r_instr[IMM_LSB +: IMM_W] : '0;
endmodule

// File: tb/tb_fu_issue_ctrl.sv
// tb_fu_issue_ctrl: directed self-checking bench for fu_issue_ctrl (FU_FLAG_REG_EN steps included when defined).
module tb_fu_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic        hold = 1'b0;
  logic        z = 1'b0, c = 1'b0, n = 1'b0, v = 1'b0;
  logic        issue_valid, mb, rw, br_taken, illegal;
  logic [4:0]  fs, sh, aa, ba, da;
  logic [31:0] imm;
  logic [14:0] br_offset;
  logic [3:0]  status;
  int n_chk = 0;
  int n_fail = 0;
  localparam logic [31:0] I_ADD  = 32'h0430_8800;
  localparam logic [31:0] I_LSL  = 32'h2253_0004;
  localparam logic [31:0] I_BZ   = 32'hC002_0010;
  localparam logic [31:0] I_BN   = 32'hC202_0123;
  localparam logic [31:0] I_ILL  = 32'h0600_0000;
  localparam logic [31:0] I_ILF  = 32'h0200_0000;
  localparam logic [31:0] I_ADDI = 32'h4410_7FFF;
  localparam logic [31:0] I_NOP  = 32'hFE00_0000;
  localparam logic [31:0] I_BC   = 32'hC400_0008;
  fu_issue_ctrl dut (
    .i_clk(clk), .i_reset(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_instr(instr), .i_hold(hold), .i_z(z), .i_c(c), .i_n(n), .i_v(v),
    .o_issue_valid(issue_valid), .o_fs(fs), .o_sh(sh), .o_aa(aa), .o_ba(ba), .o_da(da),
    .o_mb(mb), .o_imm(imm), .o_rw(rw), .o_br_taken(br_taken), .o_br_offset(br_offset),
    .o_illegal(illegal), .o_status(status)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #3;
    chk("rst_ready", in_ready, 1);
    chk("rst_ivalid", issue_valid, 0);
    chk("rst_fs", fs, 0);
    chk("rst_rw", rw, 0);
    chk("rst_br", br_taken, 0);
    chk("rst_ill", illegal, 0);
    chk("rst_imm", imm, 0);
    chk("rst_status", status, 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; instr = I_ADD;
    tick; in_valid = 1'b0; #1;
    chk("add_ivalid", issue_valid, 1);
    chk("add_fs", fs, 5'b00010);
    chk("add_aa", aa, 1);
    chk("add_ba", ba, 2);
    chk("add_da", da, 3);
    chk("add_mb", mb, 0);
    chk("add_rw", rw, 1);
    chk("add_ready", in_ready, 1);
    tick;
    chk("add_idle_ivalid", issue_valid, 0);
    chk("add_idle_rw", rw, 0);
    chk("add_idle_fs_hold", fs, 5'b00010);
    in_valid = 1'b1; instr = I_LSL;
    tick; instr = I_ADD; #1;
    chk("lsl_fs", fs, 5'b10001);
    chk("lsl_sh", sh, 4);
    chk("lsl_da", da, 5);
    chk("lsl_aa", aa, 6);
    chk("lsl_rw", rw, 1);
    chk("lsl_ready", in_ready, 1);
    tick; in_valid = 1'b0; #1;
    chk("b2b_ivalid", issue_valid, 1);
    chk("b2b_fs", fs, 5'b00010);
    chk("b2b_da", da, 3);
    chk("b2b_rw", rw, 1);
    tick;
    chk("b2b_idle", issue_valid, 0);
    in_valid = 1'b1; instr = I_BZ;
    tick; in_valid = 1'b0; z = 1'b1; #1;
    chk("bz_fs", fs, 0);
    chk("bz_aa", aa, 4);
    chk("bz_rw", rw, 0);
    chk("bz_ready", in_ready, 0);
    chk("bz_ill", illegal, 0);
    tick; z = 1'b0; #1;
    chk("bz_taken", br_taken, 1);
    chk("bz_off", br_offset, 15'h0010);
    chk("bz_br_ready", in_ready, 0);
    chk("bz_br_ivalid", issue_valid, 0);
    tick;
    chk("bz_after_taken", br_taken, 0);
    chk("bz_after_ready", in_ready, 1);
    in_valid = 1'b1; instr = I_BZ;
    tick; in_valid = 1'b0; z = 1'b0; n = 1'b1; #1;
    tick; n = 1'b0; #1;
    chk("bz0_taken", br_taken, 0);
    chk("bz0_ready", in_ready, 0);
    tick;
    in_valid = 1'b1; instr = I_BN;
    tick; in_valid = 1'b0; n = 1'b1; z = 1'b0; #1;
    chk("bn_aa", aa, 4);
    tick; n = 1'b0; #1;
    chk("bn_taken", br_taken, 1);
    chk("bn_off", br_offset, 15'h0123);
    tick;
    in_valid = 1'b1; instr = I_ILL;
    tick; in_valid = 1'b0; #1;
    chk("ill_pulse", illegal, 1);
    chk("ill_rw", rw, 0);
    chk("ill_ready", in_ready, 1);
    tick;
    chk("ill_clear", illegal, 0);
    chk("ill_idle", issue_valid, 0);
    in_valid = 1'b1; instr = I_ILF;
    tick; in_valid = 1'b0; #1;
    chk("illfs_pulse", illegal, 1);
    chk("illfs_rw", rw, 0);
    tick;
    in_valid = 1'b1; instr = I_ADDI;
    tick; in_valid = 1'b0; #1;
    chk("addi_mb", mb, 1);
    chk("addi_imm", imm, 32'h0000_7FFF);
    chk("addi_fs", fs, 5'b00010);
    chk("addi_sh", sh, 5'd31);
    chk("addi_da", da, 1);
    chk("addi_rw", rw, 1);
    tick;
    in_valid = 1'b1; instr = I_NOP;
    tick; in_valid = 1'b0; #1;
    chk("nop_ivalid", issue_valid, 1);
    chk("nop_rw", rw, 0);
    chk("nop_ill", illegal, 0);
    tick;
    in_valid = 1'b1; instr = I_ADD;
    tick; hold = 1'b1; instr = I_LSL; #1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_ivalid", issue_valid, 1);
      chk("hold_fs", fs, 5'b00010);
      chk("hold_da", da, 3);
      chk("hold_rw", rw, 0);
      chk("hold_ready", in_ready, 0);
      if (i < 2) tick;
    end
    tick; hold = 1'b0; in_valid = 1'b0; #1;
    chk("hold_rel_fs", fs, 5'b00010);
    chk("hold_rel_rw", rw, 1);
    chk("hold_rel_ready", in_ready, 1);
    tick;
    chk("hold_rel_idle", issue_valid, 0);
    chk("hold_rel_rw0", rw, 0);
    in_valid = 1'b1; instr = I_BZ;
    tick; in_valid = 1'b0; z = 1'b1; #1;
    tick; z = 1'b0; #1;
    chk("rstbr_taken_pre", br_taken, 1);
    #2 rst = 1'b1; #1;
    chk("rstbr_taken", br_taken, 0);
    chk("rstbr_ready", in_ready, 1);
    chk("rstbr_ivalid", issue_valid, 0);
    chk("rstbr_aa", aa, 0);
    chk("rstbr_off", br_offset, 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; instr = I_ADD;
    tick; in_valid = 1'b0; c = 1'b1; #1;
    chk("fl_add_rw", rw, 1);
    tick; c = 1'b0;
    in_valid = 1'b1; instr = I_BC;
    tick; in_valid = 1'b0; #1;
`ifdef FU_FLAG_REG_EN
    chk("fl_status", status, 4'b0100);
    chk("bc_ill", illegal, 0);
    chk("bc_ready", in_ready, 0);
    tick;
    chk("bc_taken", br_taken, 1);
    chk("bc_off", br_offset, 15'h0008);
    chk("bc_status_c", status[2], 1);
`else
    chk("fl_status_tied", status, 0);
    chk("bc_ill", illegal, 1);
    chk("bc_rw", rw, 0);
    tick;
    chk("bc_idle", issue_valid, 0);
    chk("bc_no_br", br_taken, 0);
`endif
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fu_issue_ctrl.md
Name: fu_issue_ctrl

Overview:
- Instruction decode and issue controller that drives the function unit's control inputs (FS, SH) and register-file addressing.
- Accepts 32-bit instruction words over a valid/ready handshake and decodes them.
- Issues one operation to the combinational function unit, samples its Z/C/N/V flags, and resolves conditional branches in a dedicated cycle.
- Sits between fetch and the datapath (register file + function unit).

Parameters:
- DATA_W, 32, datapath/immediate output width
- IMM_W, 15, immediate/branch-offset field width
- REG_AW, 5, register address width

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- IN_VALID  in  1  instruction word valid
- IN_READY  out  1  controller can accept
- INSTR  in  32  opcode[31:25] DR[24:20] SA[19:15] SB[14:10] SH[4:0] IMM[14:0]
- HOLD  in  1  downstream stall; freeze issue
- Z_in, C_in, N_in, V_in  in  1 each  function-unit flags, combinational from current FS
- ISSUE_VALID  out  1  control outputs valid this cycle
- FS  out  5  function select
- SH  out  5  shift amount
- AA, BA, DA  out  REG_AW each  source A, source B, destination
- MB  out  1  1 = B operand is IMM
- IMM  out  DATA_W  zero-extended IMM[14:0]
- RW  out  1  register write strobe
- BR_TAKEN  out  1  branch-taken pulse
- BR_OFFSET  out  IMM_W  branch offset
- ILLEGAL  out  1  undefined-opcode pulse
- STATUS  out  4  {Z,C,N,V} stored flags

Behaviour:
- Reset: state=IDLE; all outputs 0 except IN_READY=1. Reset acts immediately in any state, including mid-ISSUE or mid-BRANCH; the pending instruction is discarded.
- Legal FS set: 00000 MOVA, 00010 ADD, 00101 SUB, 00111 DEC, 01000 AND, 01010 OR, 01100 XOR, 01110 NOT, 10000 LSR, 10001 LSL.
- Opcode map:
  - 00xxxxx: register ALU, FS=opcode[4:0], MB=0.
  - 01xxxxx: immediate ALU, FS=opcode[4:0], MB=1.
  - Either class with an FS outside the legal set is illegal.
  - 1100000: BZ. 1100001: BN.
  - 1111111: NOP.
  - All other opcodes are illegal.
- Branches drive FS=00000 with AA=SA, and never write.
- States: IDLE, ISSUE, BRANCH.
- IDLE:
  - IN_READY=1.
  - IN_VALID&IN_READY latches INSTR; next state ISSUE.
- ISSUE:
  - ISSUE_VALID=1; decoded outputs driven from the latched word (latency 1 cycle accept->issue).
  - RW=ISSUE & !HOLD & ALU-class & legal.
  - ILLEGAL=ISSUE & !HOLD & illegal.
  - HOLD=1: all outputs frozen, IN_READY=0, RW=0, remain in ISSUE.
  - HOLD=0 & branch: latch condition (BZ: Z_in, BN: N_in); next state BRANCH; IN_READY=0.
  - HOLD=0 & non-branch: IN_READY=1. A back-to-back accept stays in ISSUE; otherwise go to IDLE.
- BRANCH:
  - One cycle; IN_READY=0, ISSUE_VALID=0.
  - BR_TAKEN=latched condition; BR_OFFSET=latched IMM.
  - Next state IDLE.
- Strobes: BR_TAKEN, RW and ILLEGAL are single-cycle strobes, 0 otherwise. Decoded fields hold their last value outside ISSUE.
- Widths: IMM zero-extended to DATA_W. SH passes through on all ALU ops and is ignored by the unit except for LSR/LSL.

Optional Feature:
- Macro: FU_FLAG_REG_EN.
- Defined:
  - STATUS register loads {Z_in,C_in,N_in,V_in} on every ALU-class commit (ISSUE & !HOLD & legal).
  - Opcodes 1100010 BC and 1100011 BV are legal and branch on stored C/V.
  - If an ALU op writes the flags while a BC/BV is being resolved, the BC/BV condition uses the value stored before that op.
- Undefined: STATUS tied 0; BC/BV are illegal.

Decomposition:
- Package fu_ctrl_pkg: FS_* localparams (10 codes), OPC_* opcode constants, state encodings, instruction field bit positions.
- Sub-module fu_opcode_decode: purely combinational opcode -> {FS, MB, is_alu, is_branch, br_cond_sel, legal}. The FSM and registers stay in the top.

Test Plan:
- ADD R3,R1,R2: INSTR=0x04308800 accepted -> next cycle ISSUE_VALID=1, FS=00010, AA=1, BA=2, DA=3, MB=0, RW=1 for one cycle.
- LSL R5,R6,#4: INSTR=0x22530004 -> FS=10001, SH=4, DA=5, AA=6, RW=1. Back-to-back ADD presented on the same cycle is accepted, and ISSUE persists for a second cycle.
- BZ R4,+0x10: INSTR=0xC0020010 with Z_in=1 in ISSUE -> FS=00000, AA=4, RW=0; next cycle BR_TAKEN=1, BR_OFFSET=0x0010, IN_READY=0. Repeat with Z_in=0 -> BR_TAKEN=0.
- Illegal opcode 0000011: INSTR=0x06000000 -> ILLEGAL=1 for one cycle, RW=0; the controller returns to IDLE.
- HOLD: assert HOLD for 3 cycles during an ADD issue -> outputs stable, RW=0 and IN_READY=0 throughout; RW pulses once on the cycle HOLD drops.
- Reset in BRANCH -> BR_TAKEN=0 immediately, IN_READY=1, all outputs 0. With FU_FLAG_REG_EN defined: ADD producing C_in=1, then BC -> BR_TAKEN=1, STATUS[2]=1.
